// File: rtl/beamscaler_readout_seq.sv
// beamscaler_readout_seq
// WISHBONE master that, on every scaler-period completion, reads each beam
// scaler through the scaler block's 12-bit target port and emits the values
// as one AXI-Stream packet: a header word followed by one word per scaler.
module beamscaler_readout_seq #(
   parameter int         NBEAMS      = 46,    // beams per scaler set, 1..128
   parameter int         NSCALERS    = 2,     // scaler sets, 1..2
   parameter int         ACK_TIMEOUT = 255,   // cycles to wait for ack/err, 1..255
   parameter logic [7:0] HDR_TAG     = 8'hB5  // header bits [31:24]
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,

   input  logic        enable_i,
   input  logic        done_i,
   input  logic        bank_i,

   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [11:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,

   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,

   output logic        busy_o,
   output logic        overrun_o
);

   localparam logic [6:0] LAST_BEAM = 7'(NBEAMS - 1);
   localparam logic       LAST_SET  = 1'(NSCALERS - 1);
   localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);
   localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_RD,
      ST_PUSH
   } state_t;

   state_t     state;

   // Clock-domain crossing and edge detection of the done level
   logic       done_meta;
   logic       done_sync;
   logic       done_prev;
   logic       bank_meta;
   logic       bank_sync;
   logic       done_rise;
   logic       start_evt;
   logic       miss_evt;

   // Frame bookkeeping
   logic [7:0] seq;
   logic [7:0] missed;
   logic       set_idx;
   logic [6:0] beam_idx;
   logic       nxt_set;
   logic [6:0] nxt_beam;
   logic       is_last;
   logic [7:0] tmo_cnt;
   logic       rd_timeout;
   logic       rd_done;
   logic       hdr_accept;

   // The scaler target decodes set in adr[10] and beam in adr[8:2].
   function automatic logic [11:0] scaler_addr(input logic s, input logic [6:0] b);
      return {1'b0, s, 1'b0, b, 2'b00};
   endfunction

   // The read port is read-only from this side.
   assign wb_we_o = 1'b0;

   // Two-flop synchronisers for done/bank, plus one history flop for the edge
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         done_meta <= 1'b0;
         done_sync <= 1'b0;
         done_prev <= 1'b0;
         bank_meta <= 1'b0;
         bank_sync <= 1'b0;
      end else begin
         done_meta <= done_i;
         done_sync <= done_meta;
         done_prev <= done_sync;
         bank_meta <= bank_i;
         bank_sync <= bank_meta;
      end
   end

   assign done_rise  = done_sync & ~done_prev;
   assign start_evt  = done_rise & enable_i & (state == ST_IDLE);
   assign miss_evt   = done_rise & enable_i & (state != ST_IDLE);
   assign hdr_accept = (state == ST_HDR) & m_axis_tready;

   // Index of the scaler after the current one, and whether this is the final one
   always_comb begin
      // NOTE: defaults first so no path through the block leaves a signal unassigned, which would infer a latch.
      nxt_beam = beam_idx + 7'd1;
      nxt_set  = set_idx;
      if (beam_idx == LAST_BEAM) begin
         nxt_beam = 7'd0;
         nxt_set  = set_idx + 1'b1;
      end
   end

   assign is_last    = (set_idx == LAST_SET) && (beam_idx == LAST_BEAM);
   assign rd_timeout = (tmo_cnt == TMO_LAST);
   assign rd_done    = wb_ack_i | wb_err_i | rd_timeout;

   // Count done edges that arrive while a frame is running; flag overrun
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         missed    <= 8'd0;
         overrun_o <= 1'b0;
      end else begin
         if (miss_evt) begin
            overrun_o <= 1'b1;
         end
         // The header carrying the count has been accepted, so the count
         // restarts; an edge landing in that very cycle becomes the first one.
         if (hdr_accept) begin
            missed <= miss_evt ? 8'd1 : 8'd0;
         end else if (miss_evt && (missed != 8'hFF)) begin
            missed <= missed + 8'd1;
         end
      end
   end

   // Frame sequencer: header, then a read/push pair for each scaler
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state         <= ST_IDLE;
         seq           <= 8'd0;
         set_idx       <= 1'b0;
         beam_idx      <= 7'd0;
         tmo_cnt       <= 8'd0;
         wb_cyc_o      <= 1'b0;
         wb_stb_o      <= 1'b0;
         wb_adr_o      <= 12'd0;
         m_axis_tdata  <= 32'd0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         busy_o        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_evt) begin
                  // The header is frozen here so it stays stable while the
                  // sink stalls; edges seen during the stall still raise overrun.
                  m_axis_tdata  <= {HDR_TAG, missed, 7'd0, bank_sync, seq};
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= 1'b0;
                  busy_o        <= 1'b1;
                  set_idx       <= 1'b0;
                  beam_idx      <= 7'd0;
                  state         <= ST_HDR;
               end
            end

            ST_HDR: begin
               if (m_axis_tready) begin
                  m_axis_tvalid <= 1'b0;
                  seq           <= seq + 8'd1;
                  wb_cyc_o      <= 1'b1;
                  wb_stb_o      <= 1'b1;
                  wb_adr_o      <= scaler_addr(set_idx, beam_idx);
                  tmo_cnt       <= 8'd0;
                  state         <= ST_RD;
               end
            end

            ST_RD: begin
               if (rd_done) begin
                  // Error terminations and timeouts yield the all-ones marker
                  // so the packet length never depends on target behaviour.
                  wb_cyc_o      <= 1'b0;
                  wb_stb_o      <= 1'b0;
                  m_axis_tdata  <= (wb_ack_i && !wb_err_i) ? wb_dat_i : ERR_WORD;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= is_last;
                  state         <= ST_PUSH;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end

            ST_PUSH: begin
               if (m_axis_tready) begin
                  m_axis_tvalid <= 1'b0;
                  m_axis_tlast  <= 1'b0;
                  if (is_last) begin
                     busy_o <= 1'b0;
                     state  <= ST_IDLE;
                  end else begin
                     set_idx  <= nxt_set;
                     beam_idx <= nxt_beam;
                     wb_cyc_o <= 1'b1;
                     wb_stb_o <= 1'b1;
                     wb_adr_o <= scaler_addr(nxt_set, nxt_beam);
                     tmo_cnt  <= 8'd0;
                     state    <= ST_RD;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_beamscaler_readout_seq.sv
// tb_beamscaler_readout_seq
// Directed bench: a WISHBONE target returning data = address, an AXI-Stream
// sink with fixed or random ready, and a packet-level model of every frame.
`timescale 1ns/1ps
module tb_beamscaler_readout_seq;

   localparam int NB = 46;
   localparam int NS = 2;

   logic        clk;
   logic        wb_rst_i;
   logic        enable_i;
   logic        done_i;
   logic        bank_i;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [11:0] wb_adr_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        busy_o;
   logic        overrun_o;

   beamscaler_readout_seq #(
      .NBEAMS      (NB),
      .NSCALERS    (NS),
      .ACK_TIMEOUT (255),
      .HDR_TAG     (8'hB5)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (wb_rst_i),
      .enable_i      (enable_i),
      .done_i        (done_i),
      .bank_i        (bank_i),
      .wb_cyc_o      (wb_cyc_o),
      .wb_stb_o      (wb_stb_o),
      .wb_we_o       (wb_we_o),
      .wb_adr_o      (wb_adr_o),
      .wb_dat_i      (wb_dat_i),
      .wb_ack_i      (wb_ack_i),
      .wb_err_i      (wb_err_i),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .busy_o        (busy_o),
      .overrun_o     (overrun_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run  = 0;
   int fail_count = 0;

   // Model state: expected words {tlast, tdata} of every frame still owed
   logic [32:0] exp_q[$];
   logic [31:0] pkt_words [0:127];
   int          pkt_idx    = 0;
   int          pkt_count  = 0;
   int          last_len   = 0;

   // Sink and target controls
   logic rdy_random = 1'b0;
   logic rdy_level  = 1'b1;
   logic ack_random = 1'b0;
   int   fault_mode = 0;   // 0 normal, 1 never ack set0/beam5, 2 err on it
   int   tmo_cycles = 0;
   int   cyc_starts = 0;
   logic prev_cyc   = 1'b0;
   logic prev_stall = 1'b0;
   int   wait_cnt   = 0;
   int   cur_delay  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fail_count++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Build the whole expected frame from the packet format rules
   task automatic expect_packet(input logic bank, input logic [7:0] missed,
                                input logic [7:0] seq, input int fault);
      logic [31:0] v;
      exp_q.push_back({1'b0, 8'hB5, missed, 7'd0, bank, seq});
      for (int s = 0; s < NS; s++) begin
         for (int b = 0; b < NB; b++) begin
            if (fault != 0 && s == 0 && b == 5) v = 32'hFFFF_FFFF;
            else v = 32'(s * 1024 + b * 4);
            exp_q.push_back({(s == NS - 1 && b == NB - 1), v});
         end
      end
   endtask

   // Sink ready, changed just after each active edge
   always @(posedge clk) begin
      #1;
      m_axis_tready = rdy_random ? ($urandom_range(0, 1) == 1) : rdy_level;
   end

   // WISHBONE target: data = address, ack after 0..5 wait cycles
   always @(negedge clk) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'hDEAD_BEEF;
      if (!wb_rst_i && wb_cyc_o && !prev_cyc) cyc_starts++;
      prev_cyc = wb_cyc_o;
      if (!wb_rst_i && wb_cyc_o && wb_stb_o) begin
         if (fault_mode != 0 && wb_adr_o == 12'h014) begin
            tmo_cycles++;
            if (fault_mode == 2) wb_err_i = 1'b1;
         end else if (wait_cnt >= cur_delay) begin
            wb_ack_i = 1'b1;
            wb_dat_i = {20'd0, wb_adr_o};
            check("wb_we_o", {31'd0, wb_we_o}, 32'd0);
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt  = 0;
         cur_delay = ack_random ? int'($urandom_range(0, 5)) : 0;
      end
   end

   // Compare process: every valid word must match the head of the model
   always @(negedge clk) begin
      logic [32:0] e;
      if (wb_rst_i) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("tvalid_held", {31'd0, m_axis_tvalid}, 32'd1);
         if (m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", {31'd0, m_axis_tvalid}, 32'd0);
            end else begin
               e = exp_q[0];
               check("tdata", m_axis_tdata, e[31:0]);
               check("tlast", {31'd0, m_axis_tlast}, {31'd0, e[32]});
               check("busy", {31'd0, busy_o}, 32'd1);
               if (m_axis_tready) begin
                  void'(exp_q.pop_front());
                  if (pkt_idx < 128) pkt_words[pkt_idx] = m_axis_tdata;
                  pkt_idx++;
                  if (m_axis_tlast) begin
                     last_len  = pkt_idx;
                     pkt_idx   = 0;
                     pkt_count++;
                  end
               end
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
      end
   end

   task automatic pulse_done();
      #3 done_i = 1'b1;
      repeat (6) @(posedge clk);
      #3 done_i = 1'b0;
      repeat (6) @(posedge clk);
   endtask

   task automatic wait_packet(input string name);
      int n = 0;
      int start = pkt_count;
      while (pkt_count == start && n < 20000) begin
         @(posedge clk);
         n++;
      end
      check(name, {31'd0, pkt_count != start}, 32'd1);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      wb_rst_i      = 1'b0;
      enable_i      = 1'b1;
      done_i        = 1'b0;
      bank_i        = 1'b0;
      m_axis_tready = 1'b1;
      wb_ack_i      = 1'b0;
      wb_err_i      = 1'b0;
      wb_dat_i      = 32'd0;
      #2 wb_rst_i = 1'b1;
      #4;
      check("rst_tvalid",  {31'd0, m_axis_tvalid}, 32'd0);
      check("rst_tlast",   {31'd0, m_axis_tlast}, 32'd0);
      check("rst_tdata",   m_axis_tdata, 32'd0);
      check("rst_cyc",     {31'd0, wb_cyc_o}, 32'd0);
      check("rst_stb",     {31'd0, wb_stb_o}, 32'd0);
      check("rst_adr",     {20'd0, wb_adr_o}, 32'd0);
      check("rst_busy",    {31'd0, busy_o}, 32'd0);
      check("rst_overrun", {31'd0, overrun_o}, 32'd0);
      repeat (3) @(posedge clk);
      #3 wb_rst_i = 1'b0;
      repeat (3) @(posedge clk);

      // 1: single frame, ready always high, zero-wait target, bank 1
      bank_i = 1'b1;
      cyc_starts = 0;
      expect_packet(1'b1, 8'd0, 8'd0, 0);
      pulse_done();
      wait_packet("pkt1_done");
      check("pkt1_len",    32'(last_len), 32'd93);
      check("pkt1_hdr",    pkt_words[0], 32'hB500_0100);
      check("pkt1_w1",     pkt_words[1], 32'h0000_0000);
      check("pkt1_w46",    pkt_words[46], 32'h0000_00B4);
      check("pkt1_w47",    pkt_words[47], 32'h0000_0400);
      check("pkt1_w92",    pkt_words[92], 32'h0000_04B4);
      check("pkt1_cycs",   32'(cyc_starts), 32'd92);
      check("pkt1_idle",   {31'd0, busy_o}, 32'd0);

      // 2: random ready and random ack latency, same payload
      bank_i = 1'b0;
      rdy_random = 1'b1;
      ack_random = 1'b1;
      cyc_starts = 0;
      expect_packet(1'b0, 8'd0, 8'd1, 0);
      pulse_done();
      wait_packet("pkt2_done");
      check("pkt2_hdr",  pkt_words[0], 32'hB500_0001);
      check("pkt2_cycs", 32'(cyc_starts), 32'd92);

      // 3: two extra done edges mid-frame
      expect_packet(1'b0, 8'd0, 8'd2, 0);
      pulse_done();
      repeat (20) @(posedge clk);
      pulse_done();
      pulse_done();
      check("overrun_set", {31'd0, overrun_o}, 32'd1);
      check("pkt3_busy",   {31'd0, busy_o}, 32'd1);
      wait_packet("pkt3_done");
      expect_packet(1'b0, 8'd2, 8'd3, 0);
      pulse_done();
      wait_packet("pkt4_done");
      check("pkt4_hdr", pkt_words[0], 32'hB502_0003);
      expect_packet(1'b0, 8'd0, 8'd4, 0);
      pulse_done();
      wait_packet("pkt5_done");
      check("pkt5_hdr",     pkt_words[0], 32'hB500_0004);
      check("overrun_hold", {31'd0, overrun_o}, 32'd1);

      // 4: beam 5 of set 0 never acked, then error-terminated
      rdy_random = 1'b0;
      rdy_level  = 1'b1;
      ack_random = 1'b0;
      fault_mode = 1;
      tmo_cycles = 0;
      expect_packet(1'b0, 8'd0, 8'd5, 1);
      pulse_done();
      wait_packet("pkt_tmo_done");
      check("tmo_cycles", 32'(tmo_cycles), 32'd255);
      check("tmo_w6",     pkt_words[6], 32'hFFFF_FFFF);
      check("tmo_w7",     pkt_words[7], 32'h0000_0018);
      check("tmo_len",    32'(last_len), 32'd93);
      fault_mode = 2;
      expect_packet(1'b0, 8'd0, 8'd6, 1);
      pulse_done();
      wait_packet("pkt_err_done");
      check("err_w6",  pkt_words[6], 32'hFFFF_FFFF);
      check("err_w5",  pkt_words[5], 32'h0000_0010);
      check("err_len", 32'(last_len), 32'd93);
      fault_mode = 0;

      // 5: reset while word 20 is held in PUSH
      bank_i = 1'b1;
      expect_packet(1'b1, 8'd0, 8'd7, 0);
      pulse_done();
      n = 0;
      while (pkt_idx < 20 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check("reach_w20", {31'd0, pkt_idx >= 20}, 32'd1);
      rdy_level = 1'b0;
      n = 0;
      @(posedge clk);
      while (!m_axis_tvalid && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check("w20_valid", {31'd0, m_axis_tvalid}, 32'd1);
      #2 wb_rst_i = 1'b1;
      #1;
      check("mid_tvalid",  {31'd0, m_axis_tvalid}, 32'd0);
      check("mid_tlast",   {31'd0, m_axis_tlast}, 32'd0);
      check("mid_cyc",     {31'd0, wb_cyc_o}, 32'd0);
      check("mid_stb",     {31'd0, wb_stb_o}, 32'd0);
      check("mid_busy",    {31'd0, busy_o}, 32'd0);
      check("mid_overrun", {31'd0, overrun_o}, 32'd0);
      check("mid_tdata",   m_axis_tdata, 32'd0);
      exp_q.delete();
      pkt_idx = 0;
      repeat (3) @(posedge clk);
      #3 wb_rst_i = 1'b0;
      rdy_level = 1'b1;
      bank_i = 1'b0;
      repeat (3) @(posedge clk);
      expect_packet(1'b0, 8'd0, 8'd0, 0);
      pulse_done();
      wait_packet("post_rst_done");
      check("post_rst_hdr", pkt_words[0], 32'hB500_0000);
      check("post_rst_len", 32'(last_len), 32'd93);

      // 6: enable low drops the edge; enable dropped mid-frame does not abort
      enable_i = 1'b0;
      pulse_done();
      repeat (20) @(posedge clk);
      check("dis_busy",    {31'd0, busy_o}, 32'd0);
      check("dis_tvalid",  {31'd0, m_axis_tvalid}, 32'd0);
      check("dis_overrun", {31'd0, overrun_o}, 32'd0);
      enable_i = 1'b1;
      expect_packet(1'b0, 8'd0, 8'd1, 0);
      pulse_done();
      enable_i = 1'b0;
      wait_packet("en_drop_done");
      check("en_drop_hdr", pkt_words[0], 32'hB500_0001);
      check("en_drop_len", 32'(last_len), 32'd93);
      check("en_drop_overrun", {31'd0, overrun_o}, 32'd0);
      enable_i = 1'b1;

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
